// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the 16-point sequential IFFT.
// Holds the FSM state type, the wide complex working type used by the
// butterfly arithmetic, the conjugated twiddle table and the bit-reverse helper.
package fft_pkg;

   localparam int NPT   = 16;  // transform length
   localparam int ACC_W = 48;  // working width for products and sums

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_CALC  = 2'd1,
      ST_DRAIN = 2'd2
   } ifft_state_t;

   // Complex sample in a wide container; butterfly math is done at this width
   // so nothing wraps before the final saturation.
   typedef struct packed {
      logic signed [ACC_W-1:0] re;
      logic signed [ACC_W-1:0] im;
   } cplx_t;

   // W^-k = e^(+j*2*pi*k/16), k = 0..7, in Q1.15.
   localparam int TW_RE [8] = '{32768, 30274, 23170, 12540, 0, -12540, -23170, -30274};
   localparam int TW_IM [8] = '{0, 12540, 23170, 30274, 32768, 30274, 23170, 12540};

   // Input bins are stored bit-reversed so the DIT passes end in natural order.
   function automatic logic [3:0] bitrev4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// ifft_butterfly: combinational radix-2 DIT butterfly with 1/2 scaling.
//   p  = W*b (full-precision products, >>> FRAC_BITS)
//   a' = sat((a + p) >>> 1),  b' = sat((a - p) >>> 1)
// Define IFFT16_ROUND_EN to round each halving half-up; otherwise it floors.
module ifft_butterfly
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 15
) (
   input  logic signed [1:0][DATA_WIDTH-1:0] a,
   input  logic signed [1:0][DATA_WIDTH-1:0] b,
   input  logic signed [FRAC_BITS+1:0]       w_re,
   input  logic signed [FRAC_BITS+1:0]       w_im,
   output logic signed [1:0][DATA_WIDTH-1:0] a_out,
   output logic signed [1:0][DATA_WIDTH-1:0] b_out
);

`ifdef IFFT16_ROUND_EN
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1);
`else
   localparam logic signed [ACC_W-1:0] HALF = '0;
`endif

   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
      if (v > SAT_HI) return SAT_HI[DATA_WIDTH-1:0];
      if (v < SAT_LO) return SAT_LO[DATA_WIDTH-1:0];
      return v[DATA_WIDTH-1:0];
   endfunction

   cplx_t x_a, x_b, x_w, p, sum, dif;

   // Widen operands, form the twiddle product, halve and saturate both legs.
   always_comb begin
      x_a.re = ACC_W'($signed(a[0]));
      x_a.im = ACC_W'($signed(a[1]));
      x_b.re = ACC_W'($signed(b[0]));
      x_b.im = ACC_W'($signed(b[1]));
      x_w.re = ACC_W'(w_re);
      x_w.im = ACC_W'(w_im);

      p.re   = (x_w.re * x_b.re - x_w.im * x_b.im) >>> FRAC_BITS;
      p.im   = (x_w.re * x_b.im + x_w.im * x_b.re) >>> FRAC_BITS;

      sum.re = (x_a.re + p.re + HALF) >>> 1;
      sum.im = (x_a.im + p.im + HALF) >>> 1;
      dif.re = (x_a.re - p.re + HALF) >>> 1;
      dif.im = (x_a.im - p.im + HALF) >>> 1;

      a_out[0] = sat(sum.re);
      a_out[1] = sat(sum.im);
      b_out[0] = sat(dif.re);
      b_out[1] = sat(dif.im);
   end

endmodule

// File: rtl/ifft16_seq.sv
// ifft16_seq: 16-point inverse FFT, one radix-2 DIT butterfly per cycle.
// LOAD accepts 16 bins into a bit-reversed memory, CALC runs 4 stages x 8
// butterflies in place (32 cycles), DRAIN streams y[0..15] in natural order.
// Rounding of the butterfly halving is selected with IFFT16_ROUND_EN
// (see ifft_butterfly).
module ifft16_seq
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 15
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               s_valid_i,
   output logic                               s_ready_o,
   input  logic signed [1:0][DATA_WIDTH-1:0]  s_data_i,
   output logic                               m_valid_o,
   input  logic                               m_ready_i,
   output logic signed [1:0][DATA_WIDTH-1:0]  m_data_o,
   output logic                               m_last_o
);

   localparam int TW_W = FRAC_BITS + 2;

   ifft_state_t                 state, state_nxt;
   logic [4:0]                  cnt, cnt_nxt;     // load index / {stage,butterfly} / drain index
   logic [1:0][DATA_WIDTH-1:0]  mem [NPT];

   logic [1:0]                  stg;
   logic [2:0]                  bfly, pos, grp, tw_idx;
   logic [3:0]                  addr_a, addr_b;
   logic signed [TW_W-1:0]      w_re, w_im;
   logic [1:0][DATA_WIDTH-1:0]  bf_a, bf_b;

   // Butterfly addressing: span h = 2^stg, pair (i, i+h), twiddle (i mod h)*(8>>stg).
   always_comb begin
      stg    = cnt[4:3];
      bfly   = cnt[2:0];
      pos    = bfly & ((3'd1 << stg) - 3'd1);
      grp    = bfly >> stg;
      addr_a = ({grp, 1'b0} << stg) | {1'b0, pos};
      addr_b = addr_a | (4'd1 << stg);
      tw_idx = pos << (2'd3 - stg);
      w_re   = TW_W'(TW_RE[tw_idx] >>> (15 - FRAC_BITS));
      w_im   = TW_W'(TW_IM[tw_idx] >>> (15 - FRAC_BITS));
   end

   ifft_butterfly #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_bfly (
      .a     (mem[addr_a]),
      .b     (mem[addr_b]),
      .w_re  (w_re),
      .w_im  (w_im),
      .a_out (bf_a),
      .b_out (bf_b)
   );

   // State and counter register; reset may land in any phase.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= ST_LOAD;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state, counter advance and handshake outputs.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      s_ready_o = 1'b0;
      m_valid_o = 1'b0;
      m_last_o  = 1'b0;
      m_data_o  = '0;
      case (state)
         ST_LOAD: begin
            s_ready_o = 1'b1;
            if (s_valid_i) begin
               cnt_nxt = cnt + 5'd1;
               if (cnt == 5'd15) begin
                  state_nxt = ST_CALC;
                  cnt_nxt   = '0;
               end
            end
         end
         ST_CALC: begin
            cnt_nxt = cnt + 5'd1;
            if (cnt == 5'd31) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = '0;
            end
         end
         ST_DRAIN: begin
            m_valid_o = 1'b1;
            m_last_o  = (cnt[3:0] == 4'd15);
            m_data_o  = mem[cnt[3:0]];
            if (m_ready_i) begin
               cnt_nxt = cnt + 5'd1;
               if (cnt[3:0] == 4'd15) begin
                  state_nxt = ST_LOAD;
                  cnt_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = ST_LOAD;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Sample memory: bit-reversed load writes, in-place butterfly write-back.
   // Contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk_i) begin
      if (state == ST_LOAD && s_valid_i) begin
         mem[bitrev4(cnt[3:0])] <= s_data_i;
      end else if (state == ST_CALC) begin
         mem[addr_a] <= bf_a;
         mem[addr_b] <= bf_b;
      end
   end

endmodule

// File: doc/ifft16_seq.md
IFFT16_SEQ -- requirements
Module: ifft16_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of each real or imaginary component.
REQ-002 SHALL have parameter FRAC_BITS, default 15, meaning the number of Q-format fraction bits; twiddles are Q1.FRAC_BITS in FRAC_BITS+2 bits.
REQ-003 SHALL have port clk_i  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_valid_i  input  1  input sample valid.
REQ-006 SHALL have port s_ready_o  output  1  block can accept an input sample.
REQ-007 SHALL have port s_data_i  input  [1:0][DATA_WIDTH-1:0] signed  frequency-bin sample; [0]=Re, [1]=Im.
REQ-008 SHALL have port m_valid_o  output  1  output sample valid.
REQ-009 SHALL have port m_ready_i  input  1  downstream accepts the output sample.
REQ-010 SHALL have port m_data_o  output  [1:0][DATA_WIDTH-1:0] signed  time-domain sample; [0]=Re, [1]=Im.
REQ-011 SHALL have port m_last_o  output  1  high with the 16th output sample of a frame.

Function
REQ-012 SHALL compute the 16-point inverse DFT y[n] = (1/16)·Σ X[k]·e^(+j2πkn/16) with radix-2 decimation-in-time, one butterfly per cycle, on a 16-entry internal sample memory.
REQ-013 SHALL run FSM LOAD -> CALC -> DRAIN -> LOAD; LOAD is entered on reset.
REQ-014 LOAD: s_ready_o=1; each s_valid_i&&s_ready_o transfer writes bin k (k=0..15, natural order) to address bitrev4(k); after the 16th transfer go to CALC next cycle.
REQ-015 CALC: s_ready_o=0, m_valid_o=0; exactly 32 cycles, stages s=0..3 with 8 butterflies each; span h=2^s, pair (i, i+h), twiddle index (i mod h)·(8>>s).
REQ-016 Twiddles SHALL be the conjugated table W^-k, k=0..7: Re = 32768,30274,23170,12540,0,-12540,-23170,-30274; Im = 0,12540,23170,30274,32768,30274,23170,12540.
REQ-017 Butterfly: p = W·b (full-precision products, arithmetic shift right FRAC_BITS); a' = (a+p)>>>1, b' = (a−p)>>>1, saturated to DATA_WIDTH signed; total scaling 1/16.
REQ-018 DRAIN: m_valid_o=1 starting the cycle after the last CALC cycle; samples leave in natural order n=0..15; m_last_o=1 only on n=15.
REQ-019 While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o SHALL hold stable.
REQ-020 After the transfer with m_last_o=1, SHALL return to LOAD next cycle with s_ready_o=1; no input is accepted during CALC or DRAIN.
REQ-021 s_valid_i gaps during LOAD SHALL only pause the load count; the frame is not discarded.

Reset
REQ-022 On rst_ni=0, at any time including mid-CALC or mid-DRAIN, SHALL enter LOAD with counters cleared, s_ready_o=1, m_valid_o=0, m_last_o=0, m_data_o=0; memory contents are don't-care.

Configuration
REQ-023 With IFFT16_ROUND_EN defined, each >>>1 in REQ-017 SHALL round half-up (add 1 before the shift); without it, SHALL truncate (floor).

Structure
REQ-024 The twiddle table, the bitrev4 function and the complex-sample typedef SHALL live in shared package fft_pkg.
REQ-025 The arithmetic of REQ-017 SHALL be a combinational sub-module ifft_butterfly; the FSM, address generation and memory stay in ifft16_seq.

Verification
REQ-026 X[0]=(16384,0), rest 0 -> all 16 outputs (1024,0); m_last_o only on the 16th; first m_valid_o exactly 33 cycles after the 16th input handshake.
REQ-027 X[k]=(16384,0) for all k -> y[0]=(16384,0), y[1..15]=(0,0) within ±1 LSB.
REQ-028 X[1]=(16384,0) -> y[n]≈(1024·cos(2πn/16), 1024·sin(2πn/16)), e.g. y[4]=(0,1024) ±2 LSB; check both IFFT16_ROUND_EN builds.
REQ-029 m_ready_i toggled randomly in DRAIN and s_valid_i with gaps in LOAD -> identical output sequence to REQ-026, m_data_o stable while stalled.
REQ-030 rst_ni pulsed low at CALC cycle 10 -> next cycle s_ready_o=1, m_valid_o=0; a following full frame produces correct results.
